z_alu_mc: RTL

- Parametrised, multi-cycle successor to the 16-bit combinational Z16 ALU.
- Same opcode map, generalised to WIDTH bits.
- Adds a valid/ready handshake, a full double-width multiply result, an iterative divider with remainder, and status flags.
- Sits between the register-file read stage and writeback. Downstream may stall it through i_ready.

---
 rtl/z_alu_pkg.sv | 30 +++
 rtl/z_alu_muldiv.sv | 75 +++++++
 rtl/z_alu_mc.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/z_alu_pkg.sv
// Shared opcodes, FSM states and flag bit positions for the multi-cycle ALU.
package z_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_DIV0  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL and DIV are the only opcodes that go through the iterative datapath.
    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/z_alu_muldiv.sv
// Iterative radix-2 multiply (shift-add) / restoring divide sharing one adder.
// hi_q is the product upper half or the partial remainder; lo_q is the
// multiplier being consumed or the dividend being replaced by quotient bits.
// res_* present the value the registers take on the current step, so the
// caller can capture the final result on the same edge as the last step.
module z_alu_muldiv
    import z_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    logic [WIDTH-1:0] hi_q, lo_q, mcand_q;
    logic             div_q;
    logic [WIDTH:0]   add_x, add_y;
    logic [WIDTH+1:0] add_s;
    logic             ge;
    logic [WIDTH-1:0] hi_n, lo_n;

    // One step: a single WIDTH+1-bit add, used as subtract (with carry-in) for divide.
    always_comb begin
        add_x = '0;
        add_y = '0;
        hi_n  = hi_q;
        lo_n  = lo_q;
        ge    = 1'b0;
        if (div_q) begin
            add_x = {hi_q, lo_q[WIDTH-1]};
            add_y = ~{1'b0, mcand_q};
        end else begin
            add_x = {1'b0, hi_q};
            add_y = {1'b0, (lo_q[0] ? mcand_q : '0)};
        end
        add_s = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, div_q};
        if (div_q) begin
            // Carry-out of x + ~y + 1 means the shifted remainder >= divisor.
            ge   = add_s[WIDTH+1];
            hi_n = ge ? add_s[WIDTH-1:0] : add_x[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_n = add_s[WIDTH:1];
            lo_n = {add_s[0], lo_q[WIDTH-1:1]};
        end
        res_lo = lo_n;
        res_hi = hi_n;
    end

    // Operand load on start, then one register update per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            div_q   <= 1'b0;
        end else if (start) begin
            div_q   <= is_div;
            hi_q    <= '0;
            lo_q    <= is_div ? op_b : op_a;
            mcand_q <= is_div ? op_a : op_b;
        end else if (step) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

endmodule

// File: rtl/z_alu_mc.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshake on both sides.
// Single-cycle ops are computed inline at accept; MUL/DIV run WIDTH steps
// through z_alu_muldiv. Results and flags are held until the consumer takes them.
module z_alu_mc
    import z_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic [3:0]       i_ctrl,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [WIDTH-1:0] o_data_hi,
    output logic [3:0]       o_flags
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_n;
    logic [CW-1:0]    count;
    logic             accept;
    logic             is_md;
    logic             md_last;
    logic             is_div_q;
    logic             div0_q;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [3:0]       md_flags;
    logic [WIDTH-1:0] sc_data;
    logic [3:0]       sc_flags;
    logic [WIDTH:0]   add_w, sub_w, shl_w;
    logic [SHW-1:0]   sh;

    assign is_md   = is_multi(i_ctrl);
    assign md_last = (state == ST_BUSY) && (count == CW'(1));

    // Next state and handshake outputs; DONE forwards i_ready so ops can issue back-to-back.
    always_comb begin
        state_n = state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: o_ready = 1'b1;
            ST_BUSY: if (md_last) state_n = ST_DONE;
            ST_DONE: begin
                o_valid = 1'b1;
                o_ready = i_ready;
                if (i_ready && !i_valid) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        accept = i_valid && o_ready;
        if (accept) state_n = is_md ? ST_BUSY : ST_DONE;
    end

    // Single-cycle result and flags straight from the input operands.
    always_comb begin
        sh       = i_data_a[SHW-1:0];
        add_w    = {1'b0, i_data_b} + {1'b0, i_data_a};
        sub_w    = {1'b0, i_data_b} - {1'b0, i_data_a};
        shl_w    = {1'b0, i_data_b} << sh;
        sc_data  = add_w[WIDTH-1:0];
        sc_flags = '0;
        case (i_ctrl)
            OP_SUB: begin
                sc_data            = sub_w[WIDTH-1:0];
                sc_flags[FLG_CARRY] = sub_w[WIDTH];
                sc_flags[FLG_OVF]   = (i_data_b[WIDTH-1] != i_data_a[WIDTH-1]) &&
                                      (sub_w[WIDTH-1] != i_data_b[WIDTH-1]);
            end
            OP_OR:  sc_data = i_data_b | i_data_a;
            OP_AND: sc_data = i_data_b & i_data_a;
            OP_XOR: sc_data = i_data_b ^ i_data_a;
            OP_SHL: begin
                // Bit WIDTH of the widened shift is the last bit pushed out (0 for sh==0).
                sc_data             = shl_w[WIDTH-1:0];
                sc_flags[FLG_CARRY] = shl_w[WIDTH];
            end
            OP_SHR: sc_data = i_data_b >> sh;
            default: begin
                sc_data             = add_w[WIDTH-1:0];
                sc_flags[FLG_CARRY] = add_w[WIDTH];
                sc_flags[FLG_OVF]   = (i_data_b[WIDTH-1] == i_data_a[WIDTH-1]) &&
                                      (add_w[WIDTH-1] != i_data_b[WIDTH-1]);
            end
        endcase
        sc_flags[FLG_ZERO] = (sc_data == '0);
    end

    // Flags for the iterative result, built from the final-step values.
    always_comb begin
        md_flags            = '0;
        md_flags[FLG_ZERO]  = (md_lo == '0);
        md_flags[FLG_OVF]   = !is_div_q && (md_hi != '0);
        md_flags[FLG_DIV0]  = div0_q;
    end

    // FSM state and step counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            if (accept && is_md)       count <= CW'(WIDTH);
            else if (state == ST_BUSY) count <= count - CW'(1);
        end
    end

    // Result registers: loaded at accept (single-cycle) or on the last step, held otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data    <= '0;
            o_data_hi <= '0;
            o_flags   <= '0;
            is_div_q  <= 1'b0;
            div0_q    <= 1'b0;
        end else if (accept) begin
            if (is_md) begin
                is_div_q <= (i_ctrl == OP_DIV);
                div0_q   <= (i_ctrl == OP_DIV) && (i_data_a == '0);
            end else begin
                o_data    <= sc_data;
                o_data_hi <= '0;
                o_flags   <= sc_flags;
            end
        end else if (md_last) begin
            o_data    <= md_lo;
            o_data_hi <= md_hi;
            o_flags   <= md_flags;
        end
    end

    z_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (i_clk),
        .rst    (i_rst),
        .start  (accept && is_md),
        .is_div (i_ctrl == OP_DIV),
        .step   (state == ST_BUSY),
        .op_a   (i_data_a),
        .op_b   (i_data_b),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

endmodule
